// File: rtl/cp0_irq_ctrl_if.sv
// Bus bundle for cp0_irq_ctrl: register access, interrupt lines and pipeline handshake.
interface cp0_irq_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NIRQ  = 4
);
  logic [4:0]       R_in;
  logic [4:0]       W_in;
  logic [WIDTH-1:0] Din;
  logic             WE;
  logic [NIRQ-1:0]  irq_in;
  logic [WIDTH-1:0] pc_in;
  logic             int_ack;
  logic             eret;
  logic [WIDTH-1:0] R_out;
  logic             int_req;
  logic [WIDTH-1:0] vector_out;
  logic [WIDTH-1:0] EPC_out;
  logic             IE_out;

  modport master (
    output R_in, W_in, Din, WE, irq_in, pc_in, int_ack, eret,
    input  R_out, int_req, vector_out, EPC_out, IE_out
  );

  modport slave (
    input  R_in, W_in, Din, WE, irq_in, pc_in, int_ack, eret,
    output R_out, int_req, vector_out, EPC_out, IE_out
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 style interrupt controller: count/compare timer, status/cause/EPC
// registers and a three-state request/acknowledge/return FSM.
module cp0_irq_ctrl #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NIRQ       = 4,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_0080),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(32'h0000_0010)
) (
  input  logic          clk,
  input  logic          clr,
  cp0_irq_ctrl_if.slave bus
);

  localparam int unsigned NSRC = NIRQ + 1;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] cause_q, cause_d;
  logic [WIDTH-1:0] epc_q, epc_d;

  logic [NSRC-1:0] active;
  logic [4:0]      win;
  logic            found;
  logic            ack_hit, eret_hit, timer_hit;
  logic            wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = bus.WE && (bus.W_in == 5'd9);
  assign wr_compare = bus.WE && (bus.W_in == 5'd11);
  assign wr_status  = bus.WE && (bus.W_in == 5'd12);
  assign wr_cause   = bus.WE && (bus.W_in == 5'd13);
  assign wr_epc     = bus.WE && (bus.W_in == 5'd14);

  assign ack_hit   = (state_q == REQ) && bus.int_ack;
  assign eret_hit  = (state_q == HANDLER) && bus.eret;
  assign timer_hit = (compare_q != '0) && (count_q == compare_q);

  // Lowest-index active source wins; the timer sits at index NIRQ.
  always_comb begin
    active = cause_q[8 +: NSRC] & status_q[8 +: NSRC];
    win    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (active[i] && !found) begin
        win   = 5'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (status_q[0] && !status_q[1] && found) begin
          state_d = REQ;
          idx_d   = win;
        end
      end
      REQ:     if (bus.int_ack) state_d = HANDLER;
      HANDLER: if (bus.eret)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Software writes land first; hardware EPC/EXL updates and pending sets then override.
  always_comb begin
    count_d   = wr_count ? bus.Din : count_q + WIDTH'(1);
    compare_d = wr_compare ? bus.Din : compare_q;

    status_d = wr_status ? bus.Din : status_q;
    if (ack_hit)  status_d[1] = 1'b1;
    if (eret_hit) status_d[1] = 1'b0;

    epc_d = ack_hit ? bus.pc_in : (wr_epc ? bus.Din : epc_q);

    cause_d = cause_q;
    if (ack_hit)  cause_d[4:0] = idx_q;
    if (wr_cause) cause_d = bus.Din;
    cause_d[8 +: NIRQ] = cause_d[8 +: NIRQ] | bus.irq_in;
    if (timer_hit)  cause_d[8+NIRQ] = 1'b1;
    if (wr_compare) cause_d[8+NIRQ] = 1'b0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    bus.R_out = '0;
    unique case (bus.R_in)
      5'd9:    bus.R_out = count_q;
      5'd11:   bus.R_out = compare_q;
      5'd12:   bus.R_out = status_q;
      5'd13:   bus.R_out = cause_q;
      5'd14:   bus.R_out = epc_q;
      default: bus.R_out = '0;
    endcase
  end

  assign bus.int_req    = (state_q == REQ);
  assign bus.vector_out = (state_q == REQ) ? VEC_BASE + WIDTH'(idx_q) * VEC_STRIDE : '0;
  assign bus.EPC_out    = epc_q;
  assign bus.IE_out     = status_q[0];

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: expectations queued with each stimulus step
// and compared against the DUT on the falling clock edge.
module tb_cp0_irq_ctrl;

  typedef enum int unsigned {S_REQ, S_VEC, S_EPC, S_IE, S_RD} obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic clr;
  sb_t  sb[$];
  int   n_checks;
  int   n_errors;

  cp0_irq_ctrl_if #(.WIDTH(32), .NIRQ(4)) bus ();

  cp0_irq_ctrl #(
    .WIDTH     (32),
    .NIRQ      (4),
    .VEC_BASE  (32'h0000_0080),
    .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input obs_e sel, input logic [4:0] addr,
                      input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.addr = addr;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = '0;
      case (e.sel)
        S_REQ: obs = {31'b0, bus.int_req};
        S_VEC: obs = bus.vector_out;
        S_EPC: obs = bus.EPC_out;
        S_IE:  obs = {31'b0, bus.IE_out};
        S_RD: begin
          bus.R_in = e.addr;
          #1;
          obs = bus.R_out;
        end
        default: obs = 'x;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sw_write(input logic [4:0] a, input logic [31:0] d);
    bus.W_in = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    step();
    bus.WE   = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] lines);
    bus.irq_in = lines;
    step();
    bus.irq_in = '0;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.pc_in   = pc;
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clr         = 1'b0;
    bus.R_in    = '0;
    bus.W_in    = '0;
    bus.Din     = '0;
    bus.WE      = 1'b0;
    bus.irq_in  = '0;
    bus.pc_in   = '0;
    bus.int_ack = 1'b0;
    bus.eret    = 1'b0;
    repeat (2) step();

    want("rst_req", S_REQ, 0, 0);
    want("rst_vec", S_VEC, 0, 0);
    want("rst_epc", S_EPC, 0, 0);
    want("rst_ie",  S_IE,  0, 0);
    want("rst_count", S_RD, 9, 0);
    want("rst_status", S_RD, 12, 0);
    want("rst_cause", S_RD, 13, 0);
    drain();

    clr = 1'b1;
    step();
    want("count_start", S_RD, 9, 1);
    want("rd_unmapped", S_RD, 5, 0);
    drain();

    // Basic entry: two lines pending, source 0 wins
    sw_write(5'd12, 32'h0301);
    want("ie_set", S_IE, 0, 1);
    drain();
    pulse_irq(4'b0011);
    want("pend_01", S_RD, 13, 32'h0300);
    want("no_req_yet", S_REQ, 0, 0);
    drain();
    step();
    want("req_src0", S_REQ, 0, 1);
    want("vec_src0", S_VEC, 0, 32'h80);
    drain();
    ack(32'h400);
    want("hdl_req_low", S_REQ, 0, 0);
    want("epc_entry", S_EPC, 0, 32'h400);
    want("epc_rd", S_RD, 14, 32'h400);
    want("cause_entry", S_RD, 13, 32'h0300);
    want("exl_entry", S_RD, 12, 32'h0303);
    drain();

    // No nesting while in HANDLER; re-arm only after returning to IDLE
    pulse_irq(4'b0001);
    step();
    want("hdl_no_req", S_REQ, 0, 0);
    drain();
    do_eret();
    want("eret_idle_req", S_REQ, 0, 0);
    want("eret_exl", S_RD, 12, 32'h0301);
    drain();
    step();
    want("rearm_req", S_REQ, 0, 1);
    want("rearm_vec", S_VEC, 0, 32'h80);
    drain();

    // Request held while IE and pending are cleared under it
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus.W_in = 5'd12; bus.Din = 32'h0300; bus.WE = 1'b1;
      end else if (i == 1) begin
        bus.W_in = 5'd13; bus.Din = 32'h0; bus.WE = 1'b1;
      end
      step();
      bus.WE = 1'b0;
      want($sformatf("hold_req_%0d", i), S_REQ, 0, 1);
      want($sformatf("hold_vec_%0d", i), S_VEC, 0, 32'h80);
      drain();
    end
    want("hold_ie", S_IE, 0, 0);
    want("hold_cause", S_RD, 13, 0);
    drain();

    // Hardware wins EPC over a same-cycle software write
    bus.W_in = 5'd14; bus.Din = 32'hDEAD_BEEF; bus.WE = 1'b1;
    ack(32'h500);
    bus.WE = 1'b0;
    want("epc_hw_wins", S_EPC, 0, 32'h500);
    want("status_exl_sw", S_RD, 12, 32'h0302);
    want("ack2_req", S_REQ, 0, 0);
    drain();

    // eret clears EXL even with a software status write the same cycle
    bus.W_in = 5'd12; bus.Din = 32'h0303; bus.WE = 1'b1;
    do_eret();
    bus.WE = 1'b0;
    want("eret_exl_hw", S_RD, 12, 32'h0301);
    want("eret_ie", S_IE, 0, 1);
    drain();
    step();
    want("idle_no_pend", S_REQ, 0, 0);
    drain();

    // Priority with masking: source 2 unmasked-off, source 1 wins
    pulse_irq(4'b0110);
    step();
    want("prio_req", S_REQ, 0, 1);
    want("prio_vec", S_VEC, 0, 32'h90);
    drain();
    ack(32'h600);
    want("prio_cause", S_RD, 13, 32'h0601);
    want("prio_epc", S_EPC, 0, 32'h600);
    drain();
    bus.W_in = 5'd13; bus.Din = 32'h0; bus.WE = 1'b1;
    do_eret();
    bus.WE = 1'b0;
    step();
    want("prio_cleared", S_REQ, 0, 0);
    want("prio_cause0", S_RD, 13, 0);
    drain();

    // Timer source at compare == 20
    sw_write(5'd12, 32'h1001);
    sw_write(5'd11, 32'd20);
    sw_write(5'd9, 32'd0);
    want("tmr_count0", S_RD, 9, 0);
    want("tmr_compare", S_RD, 11, 20);
    drain();
    repeat (20) step();
    want("tmr_count20", S_RD, 9, 20);
    want("tmr_not_yet", S_RD, 13, 0);
    drain();
    step();
    want("tmr_pending", S_RD, 13, 32'h1000);
    want("tmr_req_low", S_REQ, 0, 0);
    drain();
    step();
    want("tmr_req", S_REQ, 0, 1);
    want("tmr_vec", S_VEC, 0, 32'hC0);
    drain();
    ack(32'h700);
    want("tmr_cause_idx", S_RD, 13, 32'h1004);
    drain();
    sw_write(5'd11, 32'd0);
    want("tmr_cmp_clear", S_RD, 13, 32'h0004);
    drain();
    do_eret();
    want("tmr_eret_req", S_REQ, 0, 0);
    drain();

    // Asynchronous reset in the middle of a request
    sw_write(5'd12, 32'h0101);
    pulse_irq(4'b0001);
    step();
    want("pre_rst_req", S_REQ, 0, 1);
    drain();
    bus.pc_in   = 32'h777;
    bus.int_ack = 1'b1;
    #1 clr = 1'b0;
    #1;
    want("arst_req", S_REQ, 0, 0);
    want("arst_vec", S_VEC, 0, 0);
    want("arst_epc", S_EPC, 0, 0);
    want("arst_ie",  S_IE,  0, 0);
    want("arst_count", S_RD, 9, 0);
    want("arst_status", S_RD, 12, 0);
    want("arst_cause", S_RD, 13, 0);
    want("arst_rd_epc", S_RD, 14, 0);
    drain();
    step();
    bus.int_ack = 1'b0;
    clr = 1'b1;
    step();
    want("post_rst_req", S_REQ, 0, 0);
    want("post_rst_count", S_RD, 9, 1);
    want("post_rst_epc", S_EPC, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
